// File: rtl/rd_capture_sched.sv
// Read-capture scheduler: queues read commands, times them by read latency, and
// assembles one deserialised burst per command. Define RD_CAPTURE_TIMEOUT_EN for the burst watchdog.
module rd_capture_sched #(
    parameter int WIDTH       = 8,
    parameter int BURST_BEATS = 4,
    parameter int CMD_DEPTH   = 4,
    parameter int TAG_W       = 4,
    parameter int RL_W        = 7,
    parameter int TMO_CYC     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic [RL_W-1:0]              rl_cfg,
    input  logic                         rd_cmd_vld,
    input  logic [TAG_W-1:0]             rd_cmd_tag,
    output logic                         rd_cmd_rdy,
    output logic                         deser_en,
    input  logic [WIDTH-1:0]             deser_data_i,
    input  logic                         deser_rdy_i,
    output logic [WIDTH*BURST_BEATS-1:0] rd_data_o,
    output logic [TAG_W-1:0]             rd_tag_o,
    output logic                         rd_vld_o,
    output logic                         rd_err_o
);

    localparam int PTR_W  = $clog2(CMD_DEPTH);
    localparam int CNT_W  = $clog2(CMD_DEPTH + 1);
    localparam int BEAT_W = $clog2(BURST_BEATS + 1);
    localparam int SPC_W  = $clog2(BURST_BEATS + 1);
    localparam int BUS_W  = WIDTH * BURST_BEATS;

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TMO_CYC < 1) begin : g_bad_cfg
        $error("rd_capture_sched: CMD_DEPTH must be a power of 2 >= 2 and TMO_CYC >= 1");
    end

    typedef enum logic {IDLE, BURST} state_t;

    // An rl_cfg of 0 behaves as 1: the earliest a burst can start is the next cycle.
    function automatic logic [RL_W-1:0] rl_to_cd(input logic [RL_W-1:0] rl);
        return (rl == '0) ? '0 : rl - RL_W'(1);
    endfunction

    function automatic logic [SPC_W-1:0] spc_sat_inc(input logic [SPC_W-1:0] s);
        return (s >= SPC_W'(BURST_BEATS)) ? SPC_W'(BURST_BEATS) : s + SPC_W'(1);
    endfunction

    logic [TAG_W-1:0]  q_tag [CMD_DEPTH];
    logic [RL_W-1:0]   q_cd  [CMD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  q_cnt;
    logic [SPC_W-1:0]  spacing;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head_due;
    logic [TAG_W-1:0]  head_tag;

    state_t            state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [TAG_W-1:0]  cur_tag;
    logic [BUS_W-1:0]  slice;
    logic [BUS_W-1:0]  merged;
    logic              last_beat;

    logic              vld_p0;
    logic [BUS_W-1:0]  data_p0;
    logic [TAG_W-1:0]  tag_p0;

`ifdef RD_CAPTURE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0]  wdog;
    logic              tmo_hit;
    logic              err_p0;

    assign tmo_hit = (state == BURST) && !deser_rdy_i && (wdog == TMO_W'(TMO_CYC - 1));
`endif

    assign full       = (q_cnt == CNT_W'(CMD_DEPTH));
    assign empty      = (q_cnt == '0);
    assign rd_cmd_rdy = !full && (spacing >= SPC_W'(BURST_BEATS));
    assign push       = rd_cmd_vld && rd_cmd_rdy;
    assign head_due   = !empty && (q_cd[rd_ptr] == '0);
    assign head_tag   = q_tag[rd_ptr];
    assign last_beat  = (beat_cnt == BEAT_W'(BURST_BEATS - 1));
    assign pop        = head_due &&
                        ((state == IDLE) || (deser_rdy_i && last_beat));

    always_comb begin
        merged = slice;
        if (beat_cnt < BEAT_W'(BURST_BEATS)) begin
            merged[beat_cnt*WIDTH +: WIDTH] = deser_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_cnt   <= '0;
            spacing <= SPC_W'(BURST_BEATS);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                q_cnt <= q_cnt + CNT_W'(1);
            end else if (!push && pop) begin
                q_cnt <= q_cnt - CNT_W'(1);
            end
            // Spacing of 1 after an accept makes the next accept land exactly BURST_BEATS later.
            spacing <= push ? SPC_W'(1) : spc_sat_inc(spacing);
        end
    end

    // Every stored countdown ticks toward zero, so waiting entries become due in order.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < CMD_DEPTH; i++) begin
            if (push && (wr_ptr == PTR_W'(i))) begin
                q_cd[i]  <= rl_to_cd(rl_cfg);
                q_tag[i] <= rd_cmd_tag;
            end else if (q_cd[i] != '0) begin
                q_cd[i] <= q_cd[i] - RL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state    <= IDLE;
            deser_en <= 1'b0;
            beat_cnt <= '0;
            cur_tag  <= '0;
            vld_p0   <= 1'b0;
`ifdef RD_CAPTURE_TIMEOUT_EN
            err_p0   <= 1'b0;
            wdog     <= '0;
`endif
        end else begin
            vld_p0 <= 1'b0;
`ifdef RD_CAPTURE_TIMEOUT_EN
            err_p0 <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (head_due) begin
                        state    <= BURST;
                        deser_en <= 1'b1;
                        beat_cnt <= '0;
                        cur_tag  <= head_tag;
`ifdef RD_CAPTURE_TIMEOUT_EN
                        wdog     <= '0;
`endif
                    end
                end
                BURST: begin
                    if (deser_rdy_i) begin
`ifdef RD_CAPTURE_TIMEOUT_EN
                        wdog <= '0;
`endif
                        if (last_beat) begin
                            vld_p0   <= 1'b1;
                            beat_cnt <= '0;
                            // A head due right now continues the burst without dropping deser_en.
                            if (head_due) begin
                                cur_tag <= head_tag;
                            end else begin
                                state    <= IDLE;
                                deser_en <= 1'b0;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
`ifdef RD_CAPTURE_TIMEOUT_EN
                    else if (tmo_hit) begin
                        vld_p0   <= 1'b1;
                        err_p0   <= 1'b1;
                        state    <= IDLE;
                        deser_en <= 1'b0;
                    end else begin
                        wdog <= wdog + TMO_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p0: assemble beats; slice is cleared at each burst start so missing beats read 0.
    always_ff @(posedge clk_i) begin
        if (state == IDLE) begin
            if (head_due) begin
                slice <= '0;
            end
        end else if (deser_rdy_i) begin
            if (last_beat) begin
                data_p0 <= merged;
                tag_p0  <= cur_tag;
                slice   <= '0;
            end else begin
                slice <= merged;
            end
        end
`ifdef RD_CAPTURE_TIMEOUT_EN
        else if (tmo_hit) begin
            data_p0 <= slice;
            tag_p0  <= cur_tag;
        end
`endif
    end

    // Stage p1: registered outputs; data and tag hold until the next pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rd_vld_o  <= 1'b0;
            rd_data_o <= '0;
            rd_tag_o  <= '0;
        end else begin
            rd_vld_o <= vld_p0;
            if (vld_p0) begin
                rd_data_o <= data_p0;
                rd_tag_o  <= tag_p0;
            end
        end
    end

`ifdef RD_CAPTURE_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rd_err_o <= 1'b0;
        end else begin
            rd_err_o <= err_p0;
        end
    end
`else
    assign rd_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rd_capture_sched.sv
// Directed bench for rd_capture_sched: latency, back-to-back bursts, spacing/full,
// reset mid-burst and the RD_CAPTURE_TIMEOUT_EN watchdog (or its absence).
module tb_rd_capture_sched;

    logic        clk;
    logic        rst_n;
    logic [6:0]  rl_cfg;
    logic        rd_cmd_vld;
    logic [3:0]  rd_cmd_tag;
    logic        rd_cmd_rdy;
    logic        deser_en;
    logic [7:0]  deser_data_i;
    logic        deser_rdy_i;
    logic [31:0] rd_data_o;
    logic [3:0]  rd_tag_o;
    logic        rd_vld_o;
    logic        rd_err_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] beats_ab [8];

    rd_capture_sched dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .rl_cfg       (rl_cfg),
        .rd_cmd_vld   (rd_cmd_vld),
        .rd_cmd_tag   (rd_cmd_tag),
        .rd_cmd_rdy   (rd_cmd_rdy),
        .deser_en     (deser_en),
        .deser_data_i (deser_data_i),
        .deser_rdy_i  (deser_rdy_i),
        .rd_data_o    (rd_data_o),
        .rd_tag_o     (rd_tag_o),
        .rd_vld_o     (rd_vld_o),
        .rd_err_o     (rd_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        beats_ab = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        rst_n        = 1'b0;
        rl_cfg       = 7'd5;
        rd_cmd_vld   = 1'b0;
        rd_cmd_tag   = 4'd0;
        deser_data_i = 8'h00;
        deser_rdy_i  = 1'b0;

        // Reset held for two clocks
        tick();
        tick();
        check("rst_deser_en", 32'(deser_en), 32'd0);
        check("rst_rd_vld", 32'(rd_vld_o), 32'd0);
        check("rst_rd_err", 32'(rd_err_o), 32'd0);
        check("rst_rd_data", rd_data_o, 32'h0);
        check("rst_rd_tag", 32'(rd_tag_o), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_cmd_rdy", 32'(rd_cmd_rdy), 32'd1);

        // Single read, rl=5, tag=3; deser_rdy_i noise while idle must be ignored
        rl_cfg       = 7'd5;
        rd_cmd_tag   = 4'd3;
        rd_cmd_vld   = 1'b1;
        deser_rdy_i  = 1'b1;
        deser_data_i = 8'hEE;
        tick();
        rd_cmd_vld = 1'b0;
        check("single_rdy_after_accept", 32'(rd_cmd_rdy), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("single_deser_en_early", 32'(deser_en), 32'd0);
        end
        tick();
        check("single_deser_en_rise", 32'(deser_en), 32'd1);
        for (int b = 0; b < 4; b++) begin
            deser_rdy_i  = 1'b1;
            deser_data_i = 8'(8'h11 * (b + 1));
            tick();
        end
        deser_rdy_i = 1'b0;
        check("single_vld_before", 32'(rd_vld_o), 32'd0);
        check("single_deser_en_fall", 32'(deser_en), 32'd0);
        tick();
        check("single_vld", 32'(rd_vld_o), 32'd1);
        check("single_data", rd_data_o, 32'h44332211);
        check("single_tag", 32'(rd_tag_o), 32'd3);
        tick();
        check("single_vld_pulse", 32'(rd_vld_o), 32'd0);
        check("single_data_hold", rd_data_o, 32'h44332211);

        // Back-to-back: commands 4 cycles apart, both rl=5
        rd_cmd_tag = 4'd5;
        rd_cmd_vld = 1'b1;
        tick();
        rd_cmd_vld = 1'b0;
        tick();
        tick();
        tick();
        check("b2b_rdy_after_4", 32'(rd_cmd_rdy), 32'd1);
        rd_cmd_tag = 4'd6;
        rd_cmd_vld = 1'b1;
        tick();
        rd_cmd_vld = 1'b0;
        tick();
        check("b2b_deser_en_rise", 32'(deser_en), 32'd1);
        for (int i = 0; i < 8; i++) begin
            deser_rdy_i  = 1'b1;
            deser_data_i = beats_ab[i];
            tick();
            check("b2b_deser_en", 32'(deser_en), (i < 7) ? 32'd1 : 32'd0);
            check("b2b_vld", 32'(rd_vld_o), (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) begin
                check("b2b_data_a", rd_data_o, 32'hA4A3A2A1);
                check("b2b_tag_a", 32'(rd_tag_o), 32'd5);
            end
        end
        deser_rdy_i = 1'b0;
        tick();
        check("b2b_vld_b", 32'(rd_vld_o), 32'd1);
        check("b2b_data_b", rd_data_o, 32'hB4B3B2B1);
        check("b2b_tag_b", 32'(rd_tag_o), 32'd6);
        tick();
        check("b2b_vld_end", 32'(rd_vld_o), 32'd0);

        // Spacing and full: vld held high with rl=60
        rl_cfg     = 7'd60;
        rd_cmd_vld = 1'b1;
        for (int j = 0; j < 20; j++) begin
            rd_cmd_tag = 4'(8 + j / 4);
            check("space_rdy", 32'(rd_cmd_rdy), (j % 4 == 0 && j <= 12) ? 32'd1 : 32'd0);
            tick();
        end
        rd_cmd_vld = 1'b0;
        for (int j = 20; j <= 60; j++) begin
            check("full_rdy_low", 32'(rd_cmd_rdy), 32'd0);
            if (j == 60) begin
                check("full_deser_en_before_pop", 32'(deser_en), 32'd0);
            end
            tick();
        end
        check("full_rdy_after_pop", 32'(rd_cmd_rdy), 32'd1);
        check("full_deser_en_rl60", 32'(deser_en), 32'd1);

        // Reset after two beats of the first queued burst
        deser_rdy_i  = 1'b1;
        deser_data_i = 8'h55;
        tick();
        deser_data_i = 8'h66;
        tick();
        rst_n       = 1'b0;
        deser_rdy_i = 1'b0;
        tick();
        tick();
        check("midrst_deser_en", 32'(deser_en), 32'd0);
        check("midrst_vld", 32'(rd_vld_o), 32'd0);
        check("midrst_data", rd_data_o, 32'h0);
        check("midrst_cmd_rdy", 32'(rd_cmd_rdy), 32'd1);
        rst_n = 1'b1;
        for (int k = 0; k < 80; k++) begin
            tick();
            check("midrst_quiet", {30'd0, deser_en, rd_vld_o}, 32'd0);
        end

        // Stalled burst: one beat, then deser_rdy_i stops
        rl_cfg     = 7'd3;
        rd_cmd_tag = 4'd9;
        rd_cmd_vld = 1'b1;
        tick();
        rd_cmd_vld = 1'b0;
        tick();
        tick();
        tick();
        check("stall_deser_en_rise", 32'(deser_en), 32'd1);
        deser_rdy_i  = 1'b1;
        deser_data_i = 8'h11;
        tick();
        deser_rdy_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef RD_CAPTURE_TIMEOUT_EN
            check("tmo_vld", 32'(rd_vld_o), (k == 17) ? 32'd1 : 32'd0);
            check("tmo_err", 32'(rd_err_o), (k == 17) ? 32'd1 : 32'd0);
            check("tmo_deser_en", 32'(deser_en), (k < 16) ? 32'd1 : 32'd0);
            if (k == 17) begin
                check("tmo_data", rd_data_o, 32'h00000011);
                check("tmo_tag", 32'(rd_tag_o), 32'd9);
            end
`else
            check("notmo_vld", 32'(rd_vld_o), 32'd0);
            check("notmo_err", 32'(rd_err_o), 32'd0);
            check("notmo_deser_en", 32'(deser_en), 32'd1);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
